// File: rtl/ws2812_pixel_serializer.sv
// ws2812_pixel_serializer
// Accepts 24-bit GRB pixels over a valid/ready handshake and drives the
// single-wire WS2812 NRZ waveform, MSB (G7) first. After NUM_LEDS pixels the
// line is held low for the latch gap, and frame_done pulses on its last cycle.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   pixel_data   GRB pixel, sampled only at the handshake
//   pixel_valid  upstream offers pixel_data
//   pixel_ready  serializer is idle and can take a pixel
//   ws2812_out   registered WS2812 data line
//   busy         serializer is not idle
//   frame_done   one-cycle pulse on the last latch-gap cycle
//   underrun     one-cycle pulse when a mid-frame pixel is late
module ws2812_pixel_serializer #(
  parameter int unsigned NUM_LEDS  = 8,
  parameter int unsigned T0H_CYC   = 20,
  parameter int unsigned T1H_CYC   = 40,
  parameter int unsigned BIT_CYC   = 63,
  parameter int unsigned RESET_CYC = 15000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [23:0] pixel_data,
  input  logic        pixel_valid,
  output logic        pixel_ready,
  output logic        ws2812_out,
  output logic        busy,
  output logic        frame_done,
  output logic        underrun
);

  localparam int unsigned MAX_CYC = (BIT_CYC > RESET_CYC) ? BIT_CYC : RESET_CYC;
  localparam int unsigned CW      = $clog2(MAX_CYC + 1);
  localparam int unsigned PW      = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HIGH  = 2'd1,
    LOW   = 2'd2,
    LATCH = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cyc_q, cyc_d;
  logic [4:0]    bit_q, bit_d;
  logic [PW-1:0] pix_q, pix_d;
  logic [23:0]   shift_q, shift_d;
  logic          ur_flagged_q, ur_flagged_d;
  logic          frame_done_d, underrun_d;
  logic [CW-1:0] th_last, tl_last;

  // Last cycle index of the high and low phases for the bit at the MSB.
  always_comb begin
    th_last = shift_q[23] ? CW'(T1H_CYC - 1) : CW'(T0H_CYC - 1);
    tl_last = shift_q[23] ? CW'(BIT_CYC - T1H_CYC - 1) : CW'(BIT_CYC - T0H_CYC - 1);
  end

  // Next-state and registered-output decode.
  always_comb begin
    state_d      = state_q;
    cyc_d        = cyc_q;
    bit_d        = bit_q;
    pix_d        = pix_q;
    shift_d      = shift_q;
    ur_flagged_d = ur_flagged_q;
    underrun_d   = 1'b0;
    frame_done_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (pixel_valid) begin
          shift_d      = pixel_data;
          bit_d        = 5'd23;
          cyc_d        = '0;
          ur_flagged_d = 1'b0;
          state_d      = HIGH;
        end else if (pix_q != '0 && !ur_flagged_q) begin
          // Only the first late cycle of a mid-frame wait is reported.
          underrun_d   = 1'b1;
          ur_flagged_d = 1'b1;
        end
      end
      HIGH: begin
        if (cyc_q == th_last) begin
          cyc_d   = '0;
          state_d = LOW;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      LOW: begin
        if (cyc_q == tl_last) begin
          cyc_d = '0;
          if (bit_q != 5'd0) begin
            bit_d   = bit_q - 5'd1;
            shift_d = {shift_q[22:0], 1'b0};
            state_d = HIGH;
          end else if (pix_q == PW'(NUM_LEDS - 1)) begin
            state_d = LATCH;
          end else begin
            pix_d   = pix_q + PW'(1);
            state_d = IDLE;
          end
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      LATCH: begin
        if (cyc_q == CW'(RESET_CYC - 1)) begin
          cyc_d   = '0;
          pix_d   = '0;
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Registered pulse lands on the final latch cycle.
    frame_done_d = (state_d == LATCH) && (cyc_d == CW'(RESET_CYC - 1));
  end

  // State register; outputs are flopped from the next-state decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      cyc_q        <= '0;
      bit_q        <= 5'd23;
      pix_q        <= '0;
      shift_q      <= '0;
      ur_flagged_q <= 1'b0;
      ws2812_out   <= 1'b0;
      pixel_ready  <= 1'b1;
      busy         <= 1'b0;
      frame_done   <= 1'b0;
      underrun     <= 1'b0;
    end else begin
      state_q      <= state_d;
      cyc_q        <= cyc_d;
      bit_q        <= bit_d;
      pix_q        <= pix_d;
      shift_q      <= shift_d;
      ur_flagged_q <= ur_flagged_d;
      ws2812_out   <= (state_d == HIGH);
      pixel_ready  <= (state_d == IDLE);
      busy         <= (state_d != IDLE);
      frame_done   <= frame_done_d;
      underrun     <= underrun_d;
    end
  end

endmodule
